// File: rtl/onchip_ram_pkg.sv
// rtl/onchip_ram_pkg.sv - request/response packet types and helpers for the on-chip RAM responder
//
// Contents:
//   RAM_WIDTH / RAM_ADDR_WIDTH / RAM_N_ADDR_WIDTH : default field widths
//   REQ_* / RESP_* localparams                    : field offsets and packet widths
//   req_t  {data, addr, write_en, read_en, src}   : request packet, MSB first
//   resp_t {rd_data, node}                        : response packet, MSB first
//   pack_req / unpack_req / pack_resp / unpack_resp: helpers shared with the traffic generator
package onchip_ram_pkg;

    localparam int RAM_WIDTH        = 8;
    localparam int RAM_ADDR_WIDTH   = 4;
    localparam int RAM_N_ADDR_WIDTH = 4;

    // Request field offsets (LSB positions) within the packed request.
    localparam int REQ_SRC_LSB  = 0;
    localparam int REQ_RD_BIT   = RAM_N_ADDR_WIDTH;
    localparam int REQ_WR_BIT   = RAM_N_ADDR_WIDTH + 1;
    localparam int REQ_ADDR_LSB = RAM_N_ADDR_WIDTH + 2;
    localparam int REQ_DATA_LSB = REQ_ADDR_LSB + RAM_ADDR_WIDTH;
    localparam int REQ_BITS     = REQ_DATA_LSB + RAM_WIDTH;

    // Response field offsets.
    localparam int RESP_NODE_LSB = 0;
    localparam int RESP_DATA_LSB = RAM_N_ADDR_WIDTH;
    localparam int RESP_BITS     = RAM_WIDTH + RAM_N_ADDR_WIDTH;

    typedef struct packed {
        logic [RAM_WIDTH-1:0]        data;
        logic [RAM_ADDR_WIDTH-1:0]   addr;
        logic                        write_en;
        logic                        read_en;
        logic [RAM_N_ADDR_WIDTH-1:0] src;
    } req_t;

    typedef struct packed {
        logic [RAM_WIDTH-1:0]        rd_data;
        logic [RAM_N_ADDR_WIDTH-1:0] node;
    } resp_t;

    function automatic logic [REQ_BITS-1:0] pack_req(input req_t r);
        return r;
    endfunction

    function automatic req_t unpack_req(input logic [REQ_BITS-1:0] p);
        return p;
    endfunction

    function automatic logic [RESP_BITS-1:0] pack_resp(input resp_t r);
        return r;
    endfunction

    function automatic resp_t unpack_resp(input logic [RESP_BITS-1:0] p);
        return p;
    endfunction

endpackage

// File: rtl/ram_resp_fifo.sv
// rtl/ram_resp_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears pointers, count and storage)
//   push       : write push_data this edge (taken when not full, or when a pop frees a slot)
//   push_data  : entry to store
//   pop        : drop the head entry this edge (ignored when empty)
//   head_data  : current head entry, valid whenever empty is low
//   empty      : no entries held
//   count      : number of entries held (0..DEPTH)
module ram_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign do_pop = pop && !empty;
    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    assign head_data = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - NoC memory endpoint: applies writes to a RAM and answers reads with response packets
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_packed_in   : request {data, addr, write_en, read_en, src}, MSB first
//   i_valid_in    : request valid
//   i_ready_out   : request ready (registered, credit based on response space)
//   o_packed_out  : response {rd_data, NODE}, MSB first
//   o_dest_out    : response destination (request src)
//   o_valid_out   : response valid
//   o_ready_in    : NoC ready for response
//
// Optional build macro RAM_ADDR_CHECK_EN: requests with addr >= DEPTH are
// out of range; their writes are dropped and their reads return all ones.
// Without it addresses wrap modulo DEPTH.
module ram_responder
    import onchip_ram_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int DEPTH        = 16,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int NODE         = 0,
    parameter int RESP_DEPTH   = 4,
    parameter int PACKED_IN    = WIDTH + ADDR_WIDTH + N_ADDR_WIDTH + 2,
    parameter int PACKED_OUT   = WIDTH + N_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PACKED_IN-1:0]    i_packed_in,
    input  logic                    i_valid_in,
    output logic                    i_ready_out,
    output logic [PACKED_OUT-1:0]   o_packed_out,
    output logic [N_ADDR_WIDTH-1:0] o_dest_out,
    output logic                    o_valid_out,
    input  logic                    o_ready_in
);

    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_W = PACKED_OUT + N_ADDR_WIDTH;   // {rd_data, node, dest}
    localparam int CNT_W   = $clog2(RESP_DEPTH + 1);
    localparam int RES_W   = CNT_W + 1;

    localparam logic [N_ADDR_WIDTH-1:0] NODE_ID = N_ADDR_WIDTH'(NODE);

    // Request fields.
    logic [WIDTH-1:0]        req_data;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_wr;
    logic                    req_rd;
    logic [N_ADDR_WIDTH-1:0] req_src;

    assign req_data = i_packed_in[PACKED_IN-1 -: WIDTH];
    assign req_addr = i_packed_in[N_ADDR_WIDTH+2 +: ADDR_WIDTH];
    assign req_wr   = i_packed_in[N_ADDR_WIDTH+1];
    assign req_rd   = i_packed_in[N_ADDR_WIDTH];
    assign req_src  = i_packed_in[N_ADDR_WIDTH-1:0];

    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] rd_word;
    logic             wr_fire;
    logic             rd_fire;

    assign accept = i_valid_in && i_ready_out;

    // True modulo so non power-of-two depths wrap onto real words.
    assign idx = IDX_W'(32'(req_addr) % 32'(DEPTH));

`ifdef RAM_ADDR_CHECK_EN
    assign in_range = (32'(req_addr) < 32'(DEPTH));
`else
    assign in_range = 1'b1;
`endif

    logic [WIDTH-1:0] ram [DEPTH];

    // Read-first: rd_word is the pre-write contents on a combined read/write.
    assign rd_word = in_range ? ram[idx] : '1;
    assign wr_fire = accept && req_wr && in_range;
    assign rd_fire = accept && req_rd;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            ram[idx] <= req_data;
        end
    end

`ifdef RAM_ADDR_CHECK_EN
`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && accept && !in_range && (req_rd || req_wr)) begin
            $display("ram_responder warning: node %0d src %0d addr %0d out of range",
                     NODE, req_src, req_addr);
        end
    end
`endif
`endif

    // Read pipeline stage: one entry between the RAM read and the FIFO push.
    logic               pipe_valid;
    logic [ENTRY_W-1:0] pipe_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= 1'b0;
            pipe_entry <= '0;
        end else begin
            pipe_valid <= rd_fire;
            if (rd_fire) begin
                pipe_entry <= {rd_word, NODE_ID, req_src};
            end
        end
    end

    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] head;
    logic               pop;

    assign o_valid_out = !fifo_empty;
    assign pop         = o_valid_out && o_ready_in;

    ram_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_valid),
        .push_data (pipe_entry),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_packed_out = head[ENTRY_W-1 -: PACKED_OUT];
    assign o_dest_out   = head[N_ADDR_WIDTH-1:0];

    // Credit: every read holds a slot from accept until its response pops,
    // so reserved never exceeds RESP_DEPTH and a push can never overflow.
    logic [RES_W-1:0] reserved_next;

    assign reserved_next = RES_W'(fifo_count) + RES_W'(pipe_valid)
                         + RES_W'(rd_fire) - RES_W'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_ready_out <= 1'b0;
        end else begin
            i_ready_out <= (reserved_next < RES_W'(RESP_DEPTH));
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - scoreboard testbench for ram_responder
module tb_ram_responder;
    import onchip_ram_pkg::*;

    localparam int WIDTH      = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int DEPTH      = 12;
    localparam int N          = 16;
    localparam int NW         = 4;
    localparam int NODE       = 5;
    localparam int RESP_DEPTH = 4;
    localparam int PI         = WIDTH + ADDR_WIDTH + NW + 2;
    localparam int PO         = WIDTH + NW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PI-1:0] i_packed_in = '0;
    logic          i_valid_in = 1'b0;
    logic          i_ready_out;
    logic [PO-1:0] o_packed_out;
    logic [NW-1:0] o_dest_out;
    logic          o_valid_out;
    logic          o_ready_in = 1'b1;

    ram_responder #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .N          (N),
        .NODE       (NODE),
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_packed_in  (i_packed_in),
        .i_valid_in   (i_valid_in),
        .i_ready_out  (i_ready_out),
        .o_packed_out (o_packed_out),
        .o_dest_out   (o_dest_out),
        .o_valid_out  (o_valid_out),
        .o_ready_in   (o_ready_in)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int accepted = 0;

    typedef struct packed {
        logic [PO-1:0] pkt;
        logic [NW-1:0] dest;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] data, input logic [3:0] addr, input logic we,
                        input logic re, input logic [3:0] src, input logic [7:0] exp_data);
        req_t r;
        int   n;
        r.data = data; r.addr = addr; r.write_en = we; r.read_en = re; r.src = src;
        @(negedge clk);
        i_packed_in = pack_req(r);
        i_valid_in  = 1'b1;
        n = 0;
        while (!i_ready_out && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: addr 0x%0h never accepted", addr);
            i_valid_in = 1'b0;
            return;
        end
        if (re) exp_q.push_back({exp_data, 4'(NODE), src});
        @(posedge clk);
        accepted++;
        #1 i_valid_in = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: compares each popped response against the scoreboard and
    // checks that a stalled response holds steady.
    logic [PO-1:0] prev_pkt;
    logic [NW-1:0] prev_dest;
    logic          prev_stall = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_pkt", 32'(o_packed_out), 32'(prev_pkt));
                check("hold_dest", 32'(o_dest_out), 32'(prev_dest));
            end
            if (o_valid_out && o_ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got pkt 0x%0h dest %0d, required none",
                             o_packed_out, o_dest_out);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_pkt", 32'(o_packed_out), 32'(e.pkt));
                    check("resp_dest", 32'(o_dest_out), 32'(e.dest));
                end
            end
            prev_stall = o_valid_out && !o_ready_in;
            prev_pkt   = o_packed_out;
            prev_dest  = o_dest_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(i_ready_out), 0);
        check("rst_valid", 32'(o_valid_out), 0);
        check("rst_pkt", 32'(o_packed_out), 0);
        check("rst_dest", 32'(o_dest_out), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_ready", 32'(i_ready_out), 1);

        // 1. write then read with latency check
        send(8'h5A, 4'd3, 1'b1, 1'b0, 4'd7, 8'h00);
        send(8'h00, 4'd3, 1'b0, 1'b1, 4'd7, 8'h5A);
        check("lat_k", 32'(o_valid_out), 0);
        @(posedge clk);
        #1;
        check("lat_k1", 32'(o_valid_out), 1);
        wait_drain("drain_t1");

        // 2. backpressure with six reads into a four-entry FIFO
        for (int i = 0; i < 6; i++) begin
            send(8'hA0 + 8'(i), 4'(4 + i), 1'b1, 1'b0, 4'd0, 8'h00);
        end
        @(posedge clk);
        #1 o_ready_in = 1'b0;
        accepted = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(8'h00, 4'(4 + i), 1'b0, 1'b1, 4'(i + 1), 8'hA0 + 8'(i));
                end
            end
        join_none
        n = 0;
        while (accepted < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_acc4", accepted, 4);
        @(negedge clk);
        check("bp_ready_low", 32'(i_ready_out), 0);
        check("bp_valid", 32'(o_valid_out), 1);
        repeat (5) @(negedge clk);
        check("bp_stalled", accepted, 4);
        @(posedge clk);
        #1 o_ready_in = 1'b1;
        n = 0;
        while (accepted < 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_acc6", accepted, 6);
        wait_drain("drain_t2");

        // 3. read-first collision
        send(8'h11, 4'd2, 1'b1, 1'b0, 4'd1, 8'h00);
        send(8'h22, 4'd2, 1'b1, 1'b1, 4'd1, 8'h11);
        send(8'h00, 4'd2, 1'b0, 1'b1, 4'd2, 8'h22);
        wait_drain("drain_t3");

        // 4. null request
        check("null_pre_ready", 32'(i_ready_out), 1);
        send(8'hEE, 4'd5, 1'b0, 1'b0, 4'd2, 8'h00);
        check("null_post_ready", 32'(i_ready_out), 1);
        wait_drain("drain_t4");

        // 5. reset with three responses queued
        @(posedge clk);
        #1 o_ready_in = 1'b0;
        send(8'h00, 4'd4, 1'b0, 1'b1, 4'd9, 8'hA0);
        send(8'h00, 4'd5, 1'b0, 1'b1, 4'd9, 8'hA1);
        send(8'h00, 4'd6, 1'b0, 1'b1, 4'd9, 8'hA2);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(o_valid_out), 0);
        check("midrst_ready", 32'(i_ready_out), 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        o_ready_in = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_ready", 32'(i_ready_out), 1);
        send(8'h00, 4'd3, 1'b0, 1'b1, 4'd3, 8'h5A);
        wait_drain("drain_t5");

        // 6. out-of-range address 13 with DEPTH 12
        send(8'h77, 4'd1, 1'b1, 1'b0, 4'd4, 8'h00);
        send(8'h99, 4'd13, 1'b1, 1'b0, 4'd4, 8'h00);
`ifdef RAM_ADDR_CHECK_EN
        send(8'h00, 4'd1, 1'b0, 1'b1, 4'd4, 8'h77);
        send(8'h00, 4'd13, 1'b0, 1'b1, 4'd4, 8'hFF);
`else
        send(8'h00, 4'd1, 1'b0, 1'b1, 4'd4, 8'h99);
        send(8'h00, 4'd13, 1'b0, 1'b1, 4'd4, 8'h99);
`endif
        wait_drain("drain_t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
